enc_pipe_ctrl: RTL
==================

Name: enc_pipe_ctrl

Overview:
- Sequencing controller for the two-stage ECC encoder pipeline.
- Stage 1 computes the Hamming parity bits; stage 2 computes the overall parity bit and registers the final codeword.
- Accepts encode requests on a valid/ready handshake and drives both stage enables.
- Owns the registered work_mod shared by both stages, drains the pipeline before any mode change, and applies downstream backpressure.

Parameters:
- MAX_CODEWORD_WIDTH, 32, widest supported codeword (8, 16 or 32); selects the set of legal modes.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_work_mod  in  2  requested mode (00 = 8-bit, 01 = 16-bit, 10 = 32-bit codeword)
- in_ready  out  1  request accepted this cycle when high together with in_valid
- out_valid  out  1  stage-2 register holds a valid codeword
- out_ready  in  1  downstream consumes codeword
- enable_s1  out  1  load enable for the stage-1 register
- enable_s2  out  1  load enable for the stage-2 register
- work_mod  out  2  registered mode driven to both stages
- busy  out  1  pipeline non-empty or drain in progress
- mode_err  out  1  sticky: illegal mode requested
- err_clr  in  1  clears mode_err
- words_cnt  out  CNT_WIDTH  codewords delivered
- stall_cnt  out  CNT_WIDTH  cycles spent in DRAIN

Behaviour:
- Reset values (asynchronous, rst low): work_mod = 2'b00, state = IDLE, v1 = v2 = 0, mode_err = 0, both counters = 0. All outputs follow from this: in_ready, out_valid, enable_s1, enable_s2 and busy are all 0 while in reset.
- Reset mid-operation discards all in-flight words; no partial output is produced.
- Internal valid bits: v1 marks the stage-1 register, v2 marks the stage-2 register.
- out_valid = v2.
- Legal modes: width 8 accepts {00}; width 16 accepts {00, 01}; width 32 accepts {00, 01, 10}. 2'b11 is always illegal.
- adv2 = v1 && (!v2 || out_ready). enable_s2 = adv2.
- s1_free = !v1 || adv2.
- Legal request with in_work_mod == work_mod, in state IDLE or RUN:
  - in_ready = s1_free; enable_s1 = in_valid && s1_free.
  - All signals in this rule are combinational; the stage registers load on the same edge.
- v1_next = enable_s1 ? 1 : (adv2 ? 0 : v1).
- v2_next = adv2 ? 1 : ((out_valid && out_ready) ? 0 : v2).
- Latency: a request accepted at edge N appears on out_valid after edge N+1 when the pipeline is unblocked.
- Throughput: one word per cycle.
- out_ready held low freezes both stages once full, and in_ready drops to 0. No word is lost or duplicated.
- Illegal mode with in_valid:
  - in_ready = 1 (the word is consumed and dropped); enable_s1 = 0.
  - mode_err is set on the next edge.
  - If err_clr is asserted in the same cycle, set wins.
- State machine:
  - IDLE: pipeline empty. Go to RUN on any enable_s1.
  - RUN: pipeline non-empty. Go to IDLE when v1 = v2 = 0 and no new request is accepted.
  - From IDLE or RUN, a legal in_valid with in_work_mod != work_mod goes to DRAIN, with in_ready = 0 and pending_mod = in_work_mod.
  - DRAIN: in_ready = 0 while in-flight words advance normally.
  - When v1 = v2 = 0 in DRAIN: work_mod <= pending_mod, then go to IDLE.
  - Consequence: a mode switch costs at least 1 bubble cycle even from an empty pipeline.
  - If in_valid drops during DRAIN, the drain still completes and the mode still switches.
- work_mod changes only on the DRAIN-to-IDLE transition; it is never changed while v1 or v2 is set.
- busy = v1 || v2 || (state == DRAIN).

Optional Feature:
- Macro: ENC_CTRL_STATS_EN.
- Defined:
  - words_cnt increments on each out_valid && out_ready.
  - stall_cnt increments on each cycle in DRAIN.
  - Both counters saturate at all-ones and are cleared only by reset.
- Undefined: words_cnt and stall_cnt are tied to 0 and no counter flops are present.

Test Plan:
- Stream 4 words in mode 10 with out_ready = 1 → in_ready stays 1; first out_valid 2 cycles after first accept; 4 consecutive out_valid cycles; words_cnt = 4.
- Fill the pipeline, then hold out_ready = 0 for 5 cycles → v1 = v2 = 1, in_ready = 0, enable_s1 = enable_s2 = 0; on releasing out_ready, 2 words exit in order with no loss.
- Mode 10 word in flight, then request mode 01 → in_ready = 0 until out_valid drains; work_mod becomes 01 one cycle after empty; the new word is accepted next cycle; stall_cnt ≥ 2.
- MAX_CODEWORD_WIDTH = 16, request mode 10 → in_ready = 1, no enable_s1, mode_err = 1 next cycle; err_clr pulse → mode_err = 0.
- Assert rst low during a DRAIN with 2 words in flight → out_valid = 0, work_mod = 00, busy = 0 immediately; the first post-reset mode-00 word is encoded normally.
- Simultaneous out fire and new accept with the pipeline full → v1 = v2 = 1 is sustained, one word out and one word in per cycle.

Source files
------------

// File: rtl/enc_pipe_ctrl_if.sv
// Request, output and status bundle between the ECC encoder pipeline controller and its neighbours.
// The controller uses the slave modport; the request source/consumer side uses master.
interface enc_pipe_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic [1:0]           in_work_mod;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic                 enable_s1;
  logic                 enable_s2;
  logic [1:0]           work_mod;
  logic                 busy;
  logic                 mode_err;
  logic                 err_clr;
  logic [CNT_WIDTH-1:0] words_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport slave (
    input  in_valid, in_work_mod, out_ready, err_clr,
    output in_ready, out_valid, enable_s1, enable_s2, work_mod, busy, mode_err,
           words_cnt, stall_cnt
  );

  modport master (
    output in_valid, in_work_mod, out_ready, err_clr,
    input  in_ready, out_valid, enable_s1, enable_s2, work_mod, busy, mode_err,
           words_cnt, stall_cnt
  );
endinterface

// File: rtl/enc_pipe_ctrl.sv
// Sequencing controller for the two-stage ECC encoder pipeline: handshake, stage enables, mode drain.
// Optional statistics counters are built only when ENC_CTRL_STATS_EN is defined.
module enc_pipe_ctrl #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int CNT_WIDTH          = 16
) (
  input logic            clk,
  input logic            rst,
  enc_pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_v1;
  logic       r_v2;
  logic       r_mode_err;
  logic [1:0] r_work_mod;
  logic [1:0] r_pending_mod;

  logic w_legal;
  logic w_accepting;
  logic w_match;
  logic w_adv2;
  logic w_s1_free;
  logic w_out_fire;
  logic w_drop;
  logic w_switch_req;
  logic w_in_ready;
  logic w_enable_s1;
  logic w_empty;

  always_comb begin
    case (bus.in_work_mod)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = (MAX_CODEWORD_WIDTH >= 16);
      2'b10:   w_legal = (MAX_CODEWORD_WIDTH >= 32);
      default: w_legal = 1'b0;
    endcase
  end

  // Nothing is offered upstream while in reset or while the pipeline drains for a mode change.
  assign w_accepting  = rst && (r_state != DRAIN);
  assign w_match      = (bus.in_work_mod == r_work_mod);
  assign w_adv2       = r_v1 && (!r_v2 || bus.out_ready);
  assign w_s1_free    = !r_v1 || w_adv2;
  assign w_out_fire   = r_v2 && bus.out_ready;
  assign w_drop       = w_accepting && bus.in_valid && !w_legal;
  assign w_switch_req = w_accepting && bus.in_valid && w_legal && !w_match;
  assign w_in_ready   = w_accepting && (!w_legal || (w_match && w_s1_free));
  assign w_enable_s1  = w_accepting && bus.in_valid && w_legal && w_match && w_s1_free;
  assign w_empty      = !r_v1 && !r_v2;

  assign bus.in_ready  = w_in_ready;
  assign bus.enable_s1 = w_enable_s1;
  assign bus.enable_s2 = w_adv2;
  assign bus.out_valid = r_v2;
  assign bus.work_mod  = r_work_mod;
  assign bus.mode_err  = r_mode_err;
  assign bus.busy      = r_v1 || r_v2 || (r_state == DRAIN);

  // work_mod only moves once both stages are empty, so no in-flight word ever sees a mode change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_v1          <= 1'b0;
      r_v2          <= 1'b0;
      r_mode_err    <= 1'b0;
      r_work_mod    <= 2'b00;
      r_pending_mod <= 2'b00;
    end else begin
      if (w_enable_s1) begin
        r_v1 <= 1'b1;
      end else if (w_adv2) begin
        r_v1 <= 1'b0;
      end

      if (w_adv2) begin
        r_v2 <= 1'b1;
      end else if (w_out_fire) begin
        r_v2 <= 1'b0;
      end

      if (w_drop) begin
        r_mode_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_mode_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_switch_req) begin
            r_pending_mod <= bus.in_work_mod;
            r_state       <= DRAIN;
          end else if (w_enable_s1) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_switch_req) begin
            r_pending_mod <= bus.in_work_mod;
            r_state       <= DRAIN;
          end else if (w_empty && !w_enable_s1) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_work_mod <= r_pending_mod;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ENC_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] r_words_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_words_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_out_fire && (r_words_cnt != {CNT_WIDTH{1'b1}})) begin
        r_words_cnt <= r_words_cnt + 1'b1;
      end
      if ((r_state == DRAIN) && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.words_cnt = r_words_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.words_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule
